hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Sequential hazard/flush controller for the 5-stage in-order RV32 pipeline, branches resolved in ID.
//  Detects load-use, load-branch and ALU-branch RAW hazards; holds multi-cycle stalls with a counter
//  rather than re-detecting. Freezes the whole pipe on data-memory wait. Issues IF/ID flushes and ID/EX
//  bubbles for ID-taken branches and EX redirects (JALR). Drives PC, IF/ID and ID/EX control.
// PARAMETERS
//  REG_ADDR_W  5  register index width
//  LOAD_EXTRA  0  extra cycles of load latency beyond one MEM cycle (0..13)
//  CNT_W       $clog2(LOAD_EXTRA+3)  stall counter width (derived, not overridable)
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           reset, asynchronous, active-high
//  id_is_branch    in   1           ID instr compares operands in ID (branch)
//  id_uses_rs1     in   1           ID instr reads rs1
//  id_uses_rs2     in   1           ID instr reads rs2
//  id_rs1          in   REG_ADDR_W  ID source 1
//  id_rs2          in   REG_ADDR_W  ID source 2
//  ex_reg_write    in   1           EX instr writes rd
//  ex_mem_read     in   1           EX instr is a load
//  ex_rd           in   REG_ADDR_W  EX destination
//  id_branch_taken in   1           ID branch resolved taken this cycle
//  ex_redirect     in   1           EX redirects PC (JALR/mispredict)
//  mem_req         in   1           MEM stage has a data-memory access
//  mem_ready       in   1           data memory completes access this cycle
//  pc_en           out  1           PC register load enable
//  if_id_en        out  1           IF/ID register load enable
//  if_id_flush     out  1           IF/ID loads a NOP
//  id_ex_bubble    out  1           ID/EX loads zero control signals
//  pipe_freeze     out  1           hold ID/EX, EX/MEM, MEM/WB registers
//  stall_busy      out  1           RAW stall asserted this cycle
//  stall_count     out  CNT_W       stall cycles remaining after this one
// BEHAVIOUR
//  - Match m1 = id_uses_rs1 & ex_rd==id_rs1 & ex_rd!=0; m2 likewise for rs2; m = m1|m2.
//  - Hazard length N (priority order): ex_mem_read&id_is_branch&m -> 2+LOAD_EXTRA;
//    ex_mem_read&m -> 1+LOAD_EXTRA; ex_reg_write&id_is_branch&m -> 1; else 0.
//  - States: RUN, STALL, FREEZE. Registers: state, cnt[CNT_W], ret (state to resume after FREEZE).
//  - Stall cycle outputs: pc_en=0, if_id_en=0, id_ex_bubble=1, stall_busy=1, if_id_flush=0.
//  - RUN: N>0 -> stall cycle now (zero added latency, combinational); cnt<=N-1; next STALL if N>1.
//    N==0 -> pc_en=if_id_en=1, bubble=0, stall_busy=0.
//  - STALL: stall cycle; hazard inputs ignored; cnt<=cnt-1; cnt==0 -> next RUN after this cycle.
//  - stall_count = cnt in STALL, N-1 on RUN detect cycle, else 0.
//  - FREEZE entry: mem_req&!mem_ready in any state -> pc_en=if_id_en=0, pipe_freeze=1, id_ex_bubble=0,
//    if_id_flush=0, stall_busy=0; cnt held; ret<=current state (RUN/STALL). Stays while !mem_ready;
//    resumes ret with cnt unchanged; no cycle lost beyond the wait. Freeze overrides everything.
//  - id_branch_taken (not frozen, no stall this cycle): if_id_flush=1, pc_en=1. Ignored in stall cycles.
//  - ex_redirect (not frozen): highest non-freeze priority: if_id_flush=1, id_ex_bubble=1, pc_en=1,
//    if_id_en=1; aborts any stall: cnt<=0, next RUN, stall_busy=0.
//  - If redirect arrives while frozen, it is held by the frozen EX stage and acted on first unfrozen cycle.
//  - Reset (async, any state incl. mid-stall/freeze): state<=RUN, cnt<=0, ret<=RUN. While rst high:
//    pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0, stall_busy=0, stall_count=0.
//  - x0 destination never causes a stall. Counter never wraps: decrements only in STALL while cnt>0.
// TESTING
//  1 LOAD_EXTRA=0: ex_mem_read=1,ex_rd=5,id_rs1=5,id_uses_rs1=1 -> exactly 1 cycle pc_en=0,bubble=1.
//  2 Same with id_is_branch=1 -> 2 stall cycles, stall_count 1 then 0, then pc_en=1; ex_rd=0 -> no stall.
//  3 Load-branch stall cycle 1, then mem_req=1,mem_ready=0 for 3 cycles -> pipe_freeze=1, stall_count
//    holds 1; after ready, exactly 1 further stall cycle.
//  4 ex_redirect=1 in cycle 1 of a 2-cycle stall -> if_id_flush=1,id_ex_bubble=1,pc_en=1; RUN next cycle.
//  5 LOAD_EXTRA=2 load-use -> 3 stall cycles (count 2,1,0); load-branch -> 4 cycles.
//  6 rst pulse mid-stall (cnt=1) -> outputs take reset values immediately; after release, RUN, no stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard/flush
//               controller. The pipeline (master) presents the ID/EX/MEM
//               hazard and redirect information; the controller (slave)
//               returns PC, IF/ID and ID/EX control.
//               master -> slave : id_is_branch, id_uses_rs1/2, id_rs1/2,
//                                 ex_reg_write, ex_mem_read, ex_rd,
//                                 id_branch_taken, ex_redirect,
//                                 mem_req, mem_ready
//               slave -> master : pc_en, if_id_en, if_id_flush,
//                                 id_ex_bubble, pipe_freeze, stall_busy,
//                                 stall_count
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_EXTRA = 0
);
  localparam int CNT_W = $clog2(LOAD_EXTRA + 3);

  logic                  id_is_branch;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  id_branch_taken;
  logic                  ex_redirect;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  pipe_freeze;
  logic                  stall_busy;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_is_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_reg_write, ex_mem_read, ex_rd, id_branch_taken, ex_redirect,
           mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze,
           stall_busy, stall_count
  );

  modport slave (
    input  id_is_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_reg_write, ex_mem_read, ex_rd, id_branch_taken, ex_redirect,
           mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze,
           stall_busy, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard/flush controller for a 5-stage in-order RV32 pipeline
//               with branches resolved in ID. Detects load-use, load-branch
//               and ALU-branch RAW hazards and holds multi-cycle stalls with
//               a counter. Freezes the pipe on data-memory wait, flushes
//               IF/ID on taken branches and redirects, bubbles ID/EX on
//               stalls and redirects.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - hazard_ctrl_if.slave (hazard inputs / pipe control)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_EXTRA = 0
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(LOAD_EXTRA + 3);

  localparam logic [CNT_W-1:0]      C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      C_N_LOAD   = CNT_W'(LOAD_EXTRA + 1);
  localparam logic [CNT_W-1:0]      C_N_LDBR   = CNT_W'(LOAD_EXTRA + 2);
  localparam logic [REG_ADDR_W-1:0] C_REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           ret_q,   ret_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Internal copies of the outputs, driven by one combinational block.
  logic             pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic             pipe_freeze, stall_busy;
  logic [CNT_W-1:0] stall_count;

  // Hazard detection
  logic             m1, m2, m;
  logic [CNT_W-1:0] n_haz;
  logic             frozen;
  state_e           eff_state;

  assign m1 = bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1) && (bus.ex_rd != C_REG_ZERO);
  assign m2 = bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2) && (bus.ex_rd != C_REG_ZERO);
  assign m  = m1 || m2;

  always_comb begin
    n_haz = '0;
    if (bus.ex_mem_read && bus.id_is_branch && m) begin
      n_haz = C_N_LDBR;
    end else if (bus.ex_mem_read && m) begin
      n_haz = C_N_LOAD;
    end else if (bus.ex_reg_write && bus.id_is_branch && m) begin
      n_haz = C_CNT_ONE;
    end
  end

  // Once in FREEZE only mem_ready releases the pipe; the access that caused
  // the wait is still sitting in MEM, so mem_req need not stay asserted.
  assign frozen    = !bus.mem_ready && (bus.mem_req || (state_q == ST_FREEZE));
  // The cycle that ends a freeze behaves exactly like the state it interrupted.
  assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

  // cnt_q holds the number of stall cycles still to be performed. A STALL
  // cycle consumes one, so it reports cnt_q-1 as "remaining after this one",
  // while a freeze cycle consumes none and reports cnt_q unchanged.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    stall_busy   = 1'b0;
    stall_count  = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    ret_d        = ret_q;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frozen) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      pipe_freeze = 1'b1;
      stall_count = cnt_q;
      if (state_q != ST_FREEZE) begin
        ret_d = state_q;
      end
      state_d = ST_FREEZE;
    end else if (bus.ex_redirect) begin
      // A redirect squashes the instruction in ID, so any pending stall is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      cnt_d        = '0;
      state_d      = ST_RUN;
    end else if (eff_state == ST_STALL) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      stall_busy   = 1'b1;
      if (cnt_q != '0) begin
        stall_count = cnt_q - C_CNT_ONE;
        cnt_d       = cnt_q - C_CNT_ONE;
      end
      state_d = (cnt_q > C_CNT_ONE) ? ST_STALL : ST_RUN;
    end else begin
      state_d = ST_RUN;
      if (n_haz != '0) begin
        // Stall asserted in the detect cycle itself; no extra latency.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        stall_busy   = 1'b1;
        stall_count  = n_haz - C_CNT_ONE;
        cnt_d        = n_haz - C_CNT_ONE;
        state_d      = (n_haz > C_CNT_ONE) ? ST_STALL : ST_RUN;
      end else if (bus.id_branch_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.stall_busy   = stall_busy;
  assign bus.stall_count  = stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances:
//               LOAD_EXTRA=0 (u_dut0) and LOAD_EXTRA=2 (u_dut1). Each cycle
//               the expected output word is queued when stimulus is applied
//               and popped when outputs are sampled on the falling edge.
//               Output word: {pc_en, if_id_en, if_id_flush, id_ex_bubble,
//               pipe_freeze, stall_busy, stall_count[2:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.REG_ADDR_W(5), .LOAD_EXTRA(0)) b0 ();
  hazard_ctrl_if #(.REG_ADDR_W(5), .LOAD_EXTRA(2)) b1 ();

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_EXTRA(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_EXTRA(2)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       br, u1, u2;
    logic [4:0] rs1, rs2;
    logic       rw, mr;
    logic [4:0] rd;
    logic       bt, redir, mreq, mrdy;
  } stim_t;

  localparam logic [8:0] E_RUN   = 9'b110000_000;
  localparam logic [8:0] E_RST   = 9'b001100_000;
  localparam logic [8:0] E_REDIR = 9'b111100_000;
  localparam logic [8:0] E_BRT   = 9'b111000_000;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb[$];

  wire [8:0] obs0 = {b0.pc_en, b0.if_id_en, b0.if_id_flush, b0.id_ex_bubble,
                     b0.pipe_freeze, b0.stall_busy, 1'b0, b0.stall_count};
  wire [8:0] obs1 = {b1.pc_en, b1.if_id_en, b1.if_id_flush, b1.id_ex_bubble,
                     b1.pipe_freeze, b1.stall_busy, b1.stall_count};

  function automatic logic [8:0] e_stall(input int c);
    return {6'b000101, 3'(c)};
  endfunction

  function automatic logic [8:0] e_frz(input int c);
    return {6'b000010, 3'(c)};
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  // EX holds a load writing rd; ID reads rs1 (optionally a branch).
  function automatic stim_t ld(input logic [4:0] rd, input logic [4:0] rs1, input logic br);
    stim_t s = '0;
    s.mr = 1'b1; s.rw = 1'b1; s.rd = rd; s.u1 = 1'b1; s.rs1 = rs1; s.br = br;
    return s;
  endfunction

  task automatic set0(input stim_t s);
    b0.id_is_branch = s.br;  b0.id_uses_rs1 = s.u1; b0.id_uses_rs2 = s.u2;
    b0.id_rs1 = s.rs1;       b0.id_rs2 = s.rs2;     b0.ex_reg_write = s.rw;
    b0.ex_mem_read = s.mr;   b0.ex_rd = s.rd;       b0.id_branch_taken = s.bt;
    b0.ex_redirect = s.redir; b0.mem_req = s.mreq;  b0.mem_ready = s.mrdy;
  endtask

  task automatic set1(input stim_t s);
    b1.id_is_branch = s.br;  b1.id_uses_rs1 = s.u1; b1.id_uses_rs2 = s.u2;
    b1.id_rs1 = s.rs1;       b1.id_rs2 = s.rs2;     b1.ex_reg_write = s.rw;
    b1.ex_mem_read = s.mr;   b1.ex_rd = s.rd;       b1.id_branch_taken = s.bt;
    b1.ex_redirect = s.redir; b1.mem_req = s.mreq;  b1.mem_ready = s.mrdy;
  endtask

  task automatic test_reset();
    logic [8:0] want;
    rst = 1'b1;
    set0(idle()); set1(idle());
    sb.push_back(E_RST);
    @(negedge clk);
    want = sb.pop_front(); checks++;
    if (obs0 !== want) begin failures++; $display("FAIL reset_idle got=%b want=%b", obs0, want); end
    @(posedge clk); #1;
    set0(ld(5'd5, 5'd5, 1'b1));   // hazard present while in reset: still reset values
    sb.push_back(E_RST);
    @(negedge clk);
    want = sb.pop_front(); checks++;
    if (obs0 !== want) begin failures++; $display("FAIL reset_hazard got=%b want=%b", obs0, want); end
    @(posedge clk); #1;
    rst = 1'b0;
    set0(idle());
    sb.push_back(E_RUN);
    @(negedge clk);
    want = sb.pop_front(); checks++;
    if (obs0 !== want) begin failures++; $display("FAIL reset_release got=%b want=%b", obs0, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [8:0] ex[$]; stim_t t; logic [8:0] want;
    st.push_back(ld(5'd5, 5'd5, 1'b0)); ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    t = '0; t.mr = 1; t.rw = 1; t.rd = 5'd7; t.u2 = 1; t.rs2 = 5'd7; t.rs1 = 5'd7;
    st.push_back(t);                    ex.push_back(e_stall(0));   // rs2 match only
    st.push_back(idle());               ex.push_back(E_RUN);
    st.push_back(ld(5'd5, 5'd6, 1'b0)); ex.push_back(E_RUN);        // different reg
    st.push_back(ld(5'd0, 5'd0, 1'b0)); ex.push_back(E_RUN);        // x0 dest
    t = ld(5'd5, 5'd5, 1'b0); t.mr = 0;
    st.push_back(t);                    ex.push_back(E_RUN);        // ALU->ALU: forwarded
    for (int i = 0; i < st.size(); i++) begin
      set0(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t st[$]; logic [8:0] ex[$]; stim_t t; logic [8:0] want;
    st.push_back(ld(5'd5, 5'd5, 1'b1)); ex.push_back(e_stall(1));
    st.push_back(ld(5'd5, 5'd5, 1'b1)); ex.push_back(e_stall(0));   // inputs ignored
    st.push_back(idle());               ex.push_back(E_RUN);
    st.push_back(ld(5'd0, 5'd0, 1'b1)); ex.push_back(E_RUN);        // x0 dest
    t = ld(5'd9, 5'd9, 1'b1); t.mr = 0;
    st.push_back(t);                    ex.push_back(e_stall(0));   // ALU-branch
    st.push_back(idle());               ex.push_back(E_RUN);
    t = idle(); t.bt = 1;
    st.push_back(t);                    ex.push_back(E_BRT);
    t = ld(5'd5, 5'd5, 1'b1); t.bt = 1;
    st.push_back(t);                    ex.push_back(e_stall(1));   // taken ignored in stall
    t = idle(); t.bt = 1;
    st.push_back(t);                    ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      set0(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze();
    stim_t st[$]; logic [8:0] ex[$]; stim_t t; logic [8:0] want;
    st.push_back(ld(5'd5, 5'd5, 1'b1)); ex.push_back(e_stall(1));
    t = ld(5'd5, 5'd5, 1'b1); t.mreq = 1; t.mrdy = 0;
    for (int k = 0; k < 3; k++) begin st.push_back(t); ex.push_back(e_frz(1)); end
    t.mrdy = 1;
    st.push_back(t);                    ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    t = idle(); t.mreq = 1;
    st.push_back(t);                    ex.push_back(e_frz(0));     // freeze from RUN
    st.push_back(t);                    ex.push_back(e_frz(0));
    t = ld(5'd5, 5'd5, 1'b0); t.mreq = 1; t.mrdy = 1;
    st.push_back(t);                    ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    t = idle(); t.mreq = 1; t.redir = 1;
    st.push_back(t);                    ex.push_back(e_frz(0));     // redirect held
    t.mrdy = 1;
    st.push_back(t);                    ex.push_back(E_REDIR);
    st.push_back(idle());               ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      set0(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL freeze[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t st[$]; logic [8:0] ex[$]; stim_t t; logic [8:0] want;
    t = ld(5'd5, 5'd5, 1'b1); t.redir = 1;
    st.push_back(t);                    ex.push_back(E_REDIR);
    st.push_back(idle());               ex.push_back(E_RUN);
    st.push_back(ld(5'd5, 5'd5, 1'b1)); ex.push_back(e_stall(1));
    t = idle(); t.redir = 1;
    st.push_back(t);                    ex.push_back(E_REDIR);      // aborts remaining stall
    st.push_back(idle());               ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      set0(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL redirect[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] want;
    st.push_back(ld(5'd3, 5'd3, 1'b0)); ex.push_back(e_stall(0));
    st.push_back(ld(5'd4, 5'd4, 1'b0)); ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      set0(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL back_to_back[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [8:0] want;
    set0(ld(5'd5, 5'd5, 1'b1)); sb.push_back(e_stall(1));
    @(negedge clk);
    want = sb.pop_front(); checks++;
    if (obs0 !== want) begin failures++; $display("FAIL rst_mid_detect got=%b want=%b", obs0, want); end
    @(posedge clk); #1;          // now STALL with one cycle left
    rst = 1'b1;
    set0(idle()); sb.push_back(E_RST);
    #1;
    want = sb.pop_front(); checks++;
    if (obs0 !== want) begin failures++; $display("FAIL rst_mid_assert got=%b want=%b", obs0, want); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(E_RUN);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs0 !== want) begin failures++; $display("FAIL rst_mid_after[%0d] got=%b want=%b", i, obs0, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_extra2();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] want;
    st.push_back(ld(5'd5, 5'd5, 1'b0)); ex.push_back(e_stall(2));
    st.push_back(idle());               ex.push_back(e_stall(1));
    st.push_back(idle());               ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    st.push_back(ld(5'd6, 5'd6, 1'b1)); ex.push_back(e_stall(3));
    st.push_back(idle());               ex.push_back(e_stall(2));
    st.push_back(idle());               ex.push_back(e_stall(1));
    st.push_back(idle());               ex.push_back(e_stall(0));
    st.push_back(idle());               ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      set1(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (obs1 !== want) begin failures++; $display("FAIL load_extra2[%0d] got=%b want=%b", i, obs1, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_redirect();
    test_back_to_back();
    test_reset_mid_stall();
    test_load_extra2();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
